// File: rtl/triangle_checker.sv
// triangle_checker
//   Follows a stream of samples from a triangle-wave source. It tracks the
//   slope, pulses at valid peak and trough reversals, flags samples that break
//   the triangle rules, and measures the period between successive troughs.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous reset, active low
//   ena          : sample strobe; in is consumed only when ena=1
//   in           : unsigned N-bit sample
//   dir          : tracked slope (1 = rising, 0 = falling or unknown)
//   peak         : one-cycle pulse on a max -> max-1 reversal
//   trough       : one-cycle pulse on a 0 -> 1 reversal
//   err          : one-cycle pulse on a rule violation
//   err_seen     : sticky error flag, cleared only by reset
//   period       : samples between the two most recent troughs (N+1 bits)
//   period_valid : period holds a measurement taken since the last resync
//   locked       : last period was 2^(N+1)-2 and no error has occurred since
//
// State | meaning
// ------+-----------------------------------------------
// IDLE  | no sample held yet
// ACQ   | one sample held, slope unknown
// UP    | tracking a rising ramp
// DOWN  | tracking a falling ramp
module triangle_checker #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [N-1:0] in,
   output logic         dir,
   output logic         peak,
   output logic         trough,
   output logic         err,
   output logic         err_seen,
   output logic [N:0]   period,
   output logic         period_valid,
   output logic         locked
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      UP   = 2'd2,
      DOWN = 2'd3
   } state_t;

   localparam logic [N:0] ONE_W       = {{N{1'b0}}, 1'b1};
   localparam logic [N:0] MAX_W       = {1'b0, {N{1'b1}}};
   localparam logic [N:0] MAX_M1_W    = {1'b0, {(N-1){1'b1}}, 1'b0};
   localparam logic [N:0] CNT_MAX     = {(N+1){1'b1}};
   localparam logic [N:0] LOCK_PERIOD = {{N{1'b1}}, 1'b0};

   state_t       state_q, state_d;
   logic [N-1:0] prev_q, prev_d;
   logic [N:0]   cnt_q, cnt_d;
   logic [N:0]   period_q, period_d;
   logic         dir_q, dir_d;
   logic         peak_q, peak_d;
   logic         trough_q, trough_d;
   logic         err_q, err_d;
   logic         err_seen_q, err_seen_d;
   logic         period_valid_q, period_valid_d;
   logic         locked_q, locked_d;
   logic         trough_seen_q, trough_seen_d;

   // Comparisons are done one bit wider than the sample. prev=max has no +1
   // match, and prev=0 gives an all-ones -1 that a zero-extended sample can
   // never equal, so neither end wraps around.
   logic [N:0] in_w, prev_w, prev_inc, prev_dec, cnt_inc;
   logic       is_inc, is_dec;

   assign in_w     = {1'b0, in};
   assign prev_w   = {1'b0, prev_q};
   assign prev_inc = prev_w + ONE_W;
   assign prev_dec = prev_w - ONE_W;
   assign is_inc   = (in_w == prev_inc);
   assign is_dec   = (in_w == prev_dec);
   assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + ONE_W;

   logic err_ev, trough_ev;

   always_comb begin
      state_d        = state_q;
      prev_d         = prev_q;
      cnt_d          = cnt_q;
      period_d       = period_q;
      dir_d          = dir_q;
      peak_d         = 1'b0;
      trough_d       = 1'b0;
      err_d          = 1'b0;
      err_seen_d     = err_seen_q;
      period_valid_d = period_valid_q;
      locked_d       = locked_q;
      trough_seen_d  = trough_seen_q;
      err_ev         = 1'b0;
      trough_ev      = 1'b0;

      if (ena) begin
         prev_d = in;
         cnt_d  = cnt_inc;

         unique case (state_q)
            IDLE: state_d = ACQ;
            ACQ: begin
               if (is_inc) begin
                  state_d = UP;
                  dir_d   = 1'b1;
               end else if (is_dec) begin
                  state_d = DOWN;
                  dir_d   = 1'b0;
               end else begin
                  err_ev = 1'b1;
               end
            end
            UP: begin
               if (is_inc) begin
                  state_d = UP;
               end else if (prev_w == MAX_W && in_w == MAX_M1_W) begin
                  state_d = DOWN;
                  dir_d   = 1'b0;
                  peak_d  = 1'b1;
               end else begin
                  err_ev = 1'b1;
               end
            end
            DOWN: begin
               if (is_dec) begin
                  state_d = DOWN;
               end else if (prev_q == '0 && in_w == ONE_W) begin
                  state_d   = UP;
                  dir_d     = 1'b1;
                  trough_ev = 1'b1;
               end else begin
                  err_ev = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         // An error resyncs: the offending sample becomes the new reference.
         if (err_ev) begin
            state_d        = ACQ;
            err_d          = 1'b1;
            err_seen_d     = 1'b1;
            dir_d          = 1'b0;
            period_valid_d = 1'b0;
            locked_d       = 1'b0;
            trough_seen_d  = 1'b0;
         end

         if (trough_ev) begin
            trough_d      = 1'b1;
            cnt_d         = '0;
            trough_seen_d = 1'b1;
            // Only a trough preceded by another trough since resync closes a period.
            if (trough_seen_q) begin
               period_d       = cnt_inc;
               period_valid_d = 1'b1;
               locked_d       = (cnt_inc == LOCK_PERIOD);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         prev_q         <= '0;
         cnt_q          <= '0;
         period_q       <= '0;
         dir_q          <= 1'b0;
         peak_q         <= 1'b0;
         trough_q       <= 1'b0;
         err_q          <= 1'b0;
         err_seen_q     <= 1'b0;
         period_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         trough_seen_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         prev_q         <= prev_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         dir_q          <= dir_d;
         peak_q         <= peak_d;
         trough_q       <= trough_d;
         err_q          <= err_d;
         err_seen_q     <= err_seen_d;
         period_valid_q <= period_valid_d;
         locked_q       <= locked_d;
         trough_seen_q  <= trough_seen_d;
      end
   end

   assign dir          = dir_q;
   assign peak         = peak_q;
   assign trough       = trough_q;
   assign err          = err_q;
   assign err_seen     = err_seen_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign locked       = locked_q;

endmodule

// File: tb/tb_triangle_checker.sv
// tb_triangle_checker
//   Self-checking bench for triangle_checker (N=4). A behavioural model written
//   with integer arithmetic predicts every output each cycle; directed
//   scenarios add explicit checks at the interesting points.
module tb_triangle_checker;

   localparam int N      = 4;
   localparam int MAXV   = (1 << N) - 1;
   localparam int CMAX   = (1 << (N + 1)) - 1;
   localparam int LOCK_P = (1 << (N + 1)) - 2;

   logic         clk;
   logic         rst;
   logic         ena;
   logic [N-1:0] in_s;
   logic         dir, peak, trough, err, err_seen, period_valid, locked;
   logic [N:0]   period;

   triangle_checker #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .in           (in_s),
      .dir          (dir),
      .peak         (peak),
      .trough       (trough),
      .err          (err),
      .err_seen     (err_seen),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: mode 0 = nothing held, 1 = slope unknown, 2 = rising, 3 = falling
   int m_mode, m_prev, m_cnt, m_period;
   bit m_dir, m_peak, m_trough, m_err, m_err_seen, m_pv, m_locked, m_ts;

   task automatic model_step(input bit r, input bit e, input int x);
      bit bad, tr;
      bad = 0;
      tr  = 0;
      if (!r) begin
         m_mode = 0; m_prev = 0; m_cnt = 0; m_period = 0;
         m_dir = 0; m_peak = 0; m_trough = 0; m_err = 0; m_err_seen = 0;
         m_pv = 0; m_locked = 0; m_ts = 0;
         return;
      end
      m_peak = 0; m_trough = 0; m_err = 0;
      if (!e) return;
      case (m_mode)
         0: m_mode = 1;
         1: begin
            if (x == m_prev + 1)      begin m_mode = 2; m_dir = 1; end
            else if (x == m_prev - 1) begin m_mode = 3; m_dir = 0; end
            else bad = 1;
         end
         2: begin
            if (x == m_prev + 1) ;
            else if (m_prev == MAXV && x == MAXV - 1) begin m_mode = 3; m_dir = 0; m_peak = 1; end
            else bad = 1;
         end
         default: begin
            if (x == m_prev - 1) ;
            else if (m_prev == 0 && x == 1) begin m_mode = 2; m_dir = 1; tr = 1; end
            else bad = 1;
         end
      endcase
      if (bad) begin
         m_mode = 1; m_err = 1; m_err_seen = 1; m_dir = 0;
         m_pv = 0; m_locked = 0; m_ts = 0;
      end
      if (tr) begin
         m_trough = 1;
         if (m_ts) begin
            m_period = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            m_pv     = 1;
            m_locked = (m_period == LOCK_P);
         end
         m_ts  = 1;
         m_cnt = 0;
      end else begin
         m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
      m_prev = x;
   endtask

   task automatic compare_all();
      check("dir",          dir,          m_dir);
      check("peak",         peak,         m_peak);
      check("trough",       trough,       m_trough);
      check("err",          err,          m_err);
      check("err_seen",     err_seen,     m_err_seen);
      check("period",       period,       m_period);
      check("period_valid", period_valid, m_pv);
      check("locked",       locked,       m_locked);
   endtask

   // One clock: drive, let the edge happen, update model, compare 1 ns later.
   task automatic cyc(input bit r, input bit e, input int v);
      rst  = r;
      ena  = e;
      in_s = v[N-1:0];
      @(posedge clk);
      model_step(r, e, v);
      #1;
      compare_all();
   endtask

   // Walk from a to b one step at a time, with up to gap_max idle cycles before each sample.
   task automatic ramp(input int a, input int b, input int gap_max);
      int v;
      v = a;
      forever begin
         if (gap_max > 0) begin
            int g;
            g = $urandom_range(0, gap_max);
            for (int k = 0; k < g; k++) cyc(1, 0, $urandom_range(0, MAXV));
         end
         cyc(1, 1, v);
         if (v == b) break;
         v = (b > v) ? v + 1 : v - 1;
      end
   endtask

   task automatic do_reset();
      cyc(0, 1, 5);
      cyc(0, 0, 0);
   endtask

   initial begin
      rst  = 1'b0;
      ena  = 1'b0;
      in_s = '0;

      // reset state
      do_reset();
      check("rst_period", period, 0);
      check("rst_dir", dir, 0);

      // clean triangle
      ramp(0, 15, 0);
      ramp(14, 14, 0);
      check("peak_after_14", peak, 1);
      ramp(13, 0, 0);
      ramp(1, 1, 0);
      check("trough_after_1", trough, 1);
      check("pv_first_trough", period_valid, 0);
      ramp(2, 15, 0);
      ramp(14, 0, 0);
      ramp(1, 1, 0);
      check("clean_period", period, 30);
      check("clean_pv", period_valid, 1);
      check("clean_locked", locked, 1);
      check("clean_err_seen", err_seen, 0);

      // sawtooth 14,15,0
      ramp(2, 15, 0);
      cyc(1, 1, 0);
      check("saw_err", err, 1);
      check("saw_err_seen", err_seen, 1);
      check("saw_locked", locked, 0);
      check("saw_pv", period_valid, 0);
      check("saw_dir", dir, 0);
      ramp(1, 15, 0);
      ramp(14, 0, 0);
      ramp(1, 1, 0);
      check("relock_pv_first", period_valid, 0);
      ramp(2, 15, 0);
      ramp(14, 0, 0);
      ramp(1, 1, 0);
      check("relock_locked", locked, 1);
      check("relock_period", period, 30);
      check("relock_err_seen", err_seen, 1);

      // reset while locked, then resume from IDLE
      cyc(0, 1, 2);
      check("rstlk_locked", locked, 0);
      check("rstlk_err_seen", err_seen, 0);
      check("rstlk_period", period, 0);
      check("rstlk_dir", dir, 0);
      cyc(1, 1, 3);
      check("resume_dir_acq", dir, 0);
      cyc(1, 1, 4);
      check("resume_dir_up", dir, 1);
      check("resume_err", err, 0);

      // clean triangle with random ena gaps
      do_reset();
      ramp(0, 15, 3);
      ramp(14, 0, 3);
      ramp(1, 15, 3);
      ramp(14, 0, 3);
      ramp(1, 1, 3);
      check("gap_period", period, 30);
      check("gap_locked", locked, 1);

      // mid-range reversal 6,7,8,7
      do_reset();
      ramp(6, 8, 0);
      cyc(1, 1, 7);
      check("rev_err", err, 1);
      check("rev_peak", peak, 0);

      // start mid-ramp 9,8,7..
      do_reset();
      cyc(1, 1, 9);
      cyc(1, 1, 8);
      check("mid_dir", dir, 0);
      ramp(7, 0, 0);
      ramp(1, 1, 0);
      check("mid_pv_first", period_valid, 0);
      ramp(2, 15, 0);
      ramp(14, 0, 0);
      ramp(1, 1, 0);
      check("mid_period", period, 30);
      check("mid_pv", period_valid, 1);

      // randomized triangle walk with glitches, gaps and occasional resets
      begin
         int  wv;
         bit  wup;
         wv  = 0;
         wup = 1;
         do_reset();
         for (int i = 0; i < 1500; i++) begin
            bit e, r;
            int v;
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 3) != 0);
            if (e) begin
               if ($urandom_range(0, 39) == 0) begin
                  wv = $urandom_range(0, MAXV);
               end else if (wup) begin
                  if (wv == MAXV) begin wup = 0; wv = MAXV - 1; end
                  else wv++;
               end else begin
                  if (wv == 0) begin wup = 1; wv = 1; end
                  else wv--;
               end
               v = wv;
            end else begin
               v = $urandom_range(0, MAXV);
            end
            cyc(r, e, v);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/triangle_checker.md
TRIANGLE_CHECKER -- requirements
Module: triangle_checker

Interface
REQ-001 SHALL have parameter N, default 4, giving the sample width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port ena, input, 1 bit: sample strobe; in is consumed only on cycles with ena=1.
REQ-005 SHALL have port in, input, N bits: unsigned waveform sample from a triangle source.
REQ-006 SHALL have port dir, output, 1 bit: tracked slope, 1 = rising, 0 = falling or unknown.
REQ-007 SHALL have port peak, output, 1 bit: one-cycle pulse on a valid max-to-max-1 reversal.
REQ-008 SHALL have port trough, output, 1 bit: one-cycle pulse on a valid 0-to-1 reversal.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse when a sample violates the triangle rules.
REQ-010 SHALL have port err_seen, output, 1 bit: sticky error flag, cleared only by reset.
REQ-011 SHALL have port period, output, N+1 bits: samples between the two most recent trough events.
REQ-012 SHALL have port period_valid, output, 1 bit: period holds a measurement taken since the last resync.
REQ-013 SHALL have port locked, output, 1 bit: last period equals 2^(N+1)-2 and no error since that measurement.

Function
REQ-014 SHALL implement states IDLE (no sample held), ACQ (one sample held, slope unknown), UP and DOWN.
REQ-015 SHALL, when ena=0, hold all state, counters and levels, and drive peak, trough and err to 0.
REQ-016 SHALL register every output, so a response appears the cycle after the ena=1 sample that causes it.
REQ-017 SHALL store each accepted sample as prev and compare it in N+1-bit arithmetic with no wrap-around.
REQ-018 SHALL, in IDLE, take the first sample into prev and go to ACQ.
REQ-019 SHALL, in ACQ, go to UP (dir=1) if in=prev+1, go to DOWN (dir=0) if in=prev-1, and otherwise pulse err and stay in ACQ.
REQ-020 SHALL, in UP, stay in UP if in=prev+1; go to DOWN and pulse peak if prev=2^N-1 and in=2^N-2; otherwise pulse err.
REQ-021 SHALL, in DOWN, stay in DOWN if in=prev-1; go to UP and pulse trough if prev=0 and in=1; otherwise pulse err.
REQ-022 SHALL treat max followed by 0 (sawtooth), a repeated value and any reversal away from an extreme as errors.
REQ-023 SHALL, on err, set err_seen, enter ACQ holding the offending sample, and clear dir, period_valid, locked and the trough-seen flag.
REQ-024 SHALL keep a sample counter cnt of N+1 bits, incremented on each accepted sample and saturating at all-ones.
REQ-025 SHALL, on a trough event, clear cnt to 0 and set the trough-seen flag.
REQ-026 SHALL, on a trough event with trough-seen already set, load period with cnt+1 (saturating) and set period_valid.
REQ-027 SHALL update locked only at trough events, setting it to (new period = 2^(N+1)-2); it drops only on err or reset.
REQ-028 SHALL let an error take priority over the peak and trough checks for the same sample.

Reset
REQ-029 SHALL, on a clk edge with rst=0, force the state to IDLE and set prev, cnt, period, dir, peak, trough, err, err_seen, period_valid, locked and the trough-seen flag to 0.
REQ-030 SHALL let reset take priority over ena, including in mid-ramp, and SHALL resume from IDLE on the first ena=1 sample after rst returns to 1.

Verification (N=4)
REQ-031 SHALL verify: clean triangle 0,1..15,14..0,1.. with ena=1 -> peak one cycle after sample 14, trough one cycle after sample 1, period=30, period_valid=1 and locked=1 after the second trough, err_seen=0.
REQ-032 SHALL verify: the same waveform with ena low for random gaps -> identical peak and trough sequence, and period=30 (gap cycles not counted).
REQ-033 SHALL verify: sawtooth ...14,15,0 -> err pulse after sample 0, err_seen=1, locked=0, period_valid=0, dir=0; a later clean waveform relocks after two troughs with err_seen still 1.
REQ-034 SHALL verify: mid-range reversal 6,7,8,7 -> err pulse after the second 7, with no peak pulse.
REQ-035 SHALL verify: rst=0 for one cycle while locked -> all outputs 0 on the next cycle, then the state machine resumes from IDLE.
REQ-036 SHALL verify: waveform starting mid-ramp 9,8,7.. -> dir=0 after the second sample, period_valid stays 0 through the first trough, and period=30 after the second trough.
